prng_reader: RTL and testbench

PRNG_READER -- requirements
Module: prng_reader

---
 rtl/prng_pkg.sv | 22 ++
 rtl/prng_fifo.sv | 72 +++++++
 rtl/prng_reader.sv | 91 +++++++++
 tb/tb_prng_reader.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/prng_pkg.sv
// rtl/prng_pkg.sv - shared constants and types for the PRNG prefetch reader
package prng_pkg;

    // Prefetch FIFO depth in 32-bit words
    localparam int DEPTH_DEFAULT = 4;

    // Number of 32-bit state words in one generator seed
    localparam int SEED_WORDS = 4;

    // Reader operating mode: prefetching, or part-way through a seed load
    typedef enum logic [0:0] {
        FILL = 1'b0,
        SEED = 1'b1
    } state_t;

    // Generator power-up state (s0..s3); first word produced is 0xFEF316C3
    localparam logic [31:0] GEN_SEED_S0 = 32'h1234_5678;
    localparam logic [31:0] GEN_SEED_S1 = 32'h9ABC_DEF0;
    localparam logic [31:0] GEN_SEED_S2 = 32'h0FED_CBA9;
    localparam logic [31:0] GEN_SEED_S3 = 32'h85A5_2708;

endpackage

// File: rtl/prng_fifo.sv
// rtl/prng_fifo.sv - synchronous word FIFO with push, pop, flush and level
module prng_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [31:0]              push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [31:0]              head,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          empty;
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign empty = (level == '0);
    assign full  = (level == LW'(DEPTH));

    // Flush overrides both sides; a push into a full FIFO is only taken
    // when a pop frees the head slot in the same cycle.
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & ~flush & (~full | do_pop);

    assign head = empty ? 32'h0 : mem[rd_ptr];

    // Storage write; cleared to zero on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Wrap-around pointers and occupancy count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                level <= level + LW'(1);
            end else if (!do_push && do_pop) begin
                level <= level - LW'(1);
            end
        end
    end

endmodule

// File: rtl/prng_reader.sv
// rtl/prng_reader.sv - prefetches generator words into a FIFO and loads seeds
module prng_reader
    import prng_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic                     gen_next,
    input  logic [31:0]              gen_rnd,
    output logic                     gen_write,
    output logic [1:0]               gen_write_addr,
    output logic [31:0]              gen_write_data,
    input  logic                     seed_valid,
    input  logic [31:0]              seed_data,
    output logic                     seed_ready,
    output logic                     out_valid,
    output logic [31:0]              out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam int PW = LW + 1;
    localparam logic [1:0] LAST_IDX = 2'(SEED_WORDS - 1);

    state_t        state;
    logic [1:0]    seed_idx;
    logic          pending;
    logic          accept;
    logic          flush;
    logic          push;
    logic          pop;
    logic [31:0]   head;
    logic [PW-1:0] projected;

    // Seeds are accepted in both modes; gating with rst_n keeps every
    // strobe low while reset is held.
    assign seed_ready = rst_n;
    assign accept     = seed_valid & seed_ready;
    assign flush      = accept & (seed_idx == 2'd0);

    assign gen_write      = accept;
    assign gen_write_addr = accept ? seed_idx : 2'd0;
    assign gen_write_data = accept ? seed_data : 32'h0;

    // The pending flag is exactly this cycle's capture of gen_rnd; a flush
    // discards it together with the FIFO contents and any pop.
    assign push = pending & ~flush;
    assign pop  = out_ready & out_valid & ~flush;

    // Occupancy once this cycle's push/pop land; a new request must fit.
    assign projected = PW'(level) + PW'(pending) - PW'(pop);
    assign gen_next  = rst_n & (state == FILL) & ~accept & (projected < PW'(DEPTH));

    assign out_valid = (level != '0);
    assign out_data  = head;

    // Capture flag, seed word index and mode tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FILL;
            seed_idx <= 2'd0;
            pending  <= 1'b0;
        end else begin
            pending <= gen_next & ~flush;
            if (accept) begin
                seed_idx <= seed_idx + 2'd1;
                if (seed_idx == 2'd0) begin
                    state <= SEED;
                end else if (seed_idx == LAST_IDX) begin
                    state <= FILL;
                end
            end
        end
    end

    prng_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (gen_rnd),
        .pop       (pop),
        .flush     (flush),
        .head      (head),
        .level     (level)
    );

endmodule

// File: tb/tb_prng_reader.sv
// tb/tb_prng_reader.sv - self-checking bench for prng_reader with xoshiro128++ model
module tb_prng_reader;
    import prng_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        gen_next;
    logic [31:0] gen_rnd = 32'h0;
    logic        gen_write;
    logic [1:0]  gen_write_addr;
    logic [31:0] gen_write_data;
    logic        seed_valid;
    logic [31:0] seed_data;
    logic        seed_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic [2:0]  level;

    int vectors = 0;
    int miscompares = 0;

    // generator state {s3, s2, s1, s0}
    logic [127:0] gs = {GEN_SEED_S3, GEN_SEED_S2, GEN_SEED_S1, GEN_SEED_S0};

    logic [31:0] sb [$];
    int          bidx = 0;
    int          pop_cnt = 0;
    int          max_level = 0;
    int          both_cnt = 0;
    logic        samp_gen_next;
    logic        samp_gen_write;
    logic        samp_out_valid;
    logic [1:0]  samp_addr;
    logic [31:0] samp_data;
    logic [2:0]  samp_level;

    prng_reader #(.DEPTH(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .gen_next       (gen_next),
        .gen_rnd        (gen_rnd),
        .gen_write      (gen_write),
        .gen_write_addr (gen_write_addr),
        .gen_write_data (gen_write_data),
        .seed_valid     (seed_valid),
        .seed_data      (seed_data),
        .seed_ready     (seed_ready),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_ready      (out_ready),
        .level          (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int k);
        return (x << k) | (x >> (32 - k));
    endfunction

    function automatic logic [31:0] xo_out(input logic [127:0] s);
        return rotl(s[31:0] + s[127:96], 7) + s[31:0];
    endfunction

    function automatic logic [127:0] xo_next(input logic [127:0] s);
        logic [31:0] s0, s1, s2, s3, t;
        s0 = s[31:0]; s1 = s[63:32]; s2 = s[95:64]; s3 = s[127:96];
        t  = s1 << 9;
        s2 = s2 ^ s0;
        s3 = s3 ^ s1;
        s1 = s1 ^ s2;
        s0 = s0 ^ s3;
        s2 = s2 ^ t;
        s3 = rotl(s3, 11);
        return {s3, s2, s1, s0};
    endfunction

    // generator: registered output word, advanced on gen_next, loaded on gen_write
    always @(posedge clk) begin
        if (gen_next) begin
            gen_rnd <= xo_out(gs);
            gs      <= xo_next(gs);
        end else if (gen_write) begin
            gs[32*gen_write_addr +: 32] <= gen_write_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // one cycle: sample mid-cycle, run the scoreboard, step to 1 after the next edge
    task automatic tick();
        #4;
        samp_gen_next  = gen_next;
        samp_gen_write = gen_write;
        samp_out_valid = out_valid;
        samp_addr      = gen_write_addr;
        samp_data      = gen_write_data;
        samp_level     = level;
        if (gen_next && gen_write) both_cnt++;
        if (int'(level) > max_level) max_level = int'(level);
        if (seed_valid && seed_ready && bidx == 0) begin
            sb.delete();
        end else if (out_valid && out_ready) begin
            pop_cnt++;
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $error("FAIL pop_sb_empty observed=%08h expected=none", out_data);
            end else begin
                chk("pop_data", out_data, sb.pop_front());
            end
        end
        if (seed_valid && seed_ready) bidx = (bidx + 1) % 4;
        if (gen_next) sb.push_back(xo_out(gs));
        @(posedge clk);
        #1;
    endtask

    task automatic seed_word(input logic [31:0] d, input int idx);
        seed_valid = 1'b1;
        seed_data  = d;
        tick();
        chk("seed_write", 32'(samp_gen_write), 32'd1);
        chk("seed_addr", 32'(samp_addr), 32'(idx));
        chk("seed_data", samp_data, d);
        chk("seed_no_next", 32'(samp_gen_next), 32'd0);
        seed_valid = 1'b0;
    endtask

    task automatic reset_outputs_zero(input string tag);
        chk({tag, "_gen_next"}, 32'(gen_next), 32'd0);
        chk({tag, "_gen_write"}, 32'(gen_write), 32'd0);
        chk({tag, "_addr"}, 32'(gen_write_addr), 32'd0);
        chk({tag, "_wdata"}, gen_write_data, 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_data"}, out_data, 32'd0);
        chk({tag, "_seed_ready"}, 32'(seed_ready), 32'd0);
        chk({tag, "_level"}, 32'(level), 32'd0);
    endtask

    initial begin
        int pulses;
        rst_n      = 1'b0;
        seed_valid = 1'b1;
        seed_data  = 32'hAAAA_5555;
        out_ready  = 1'b1;

        // reset with inputs active: every output held low
        repeat (2) @(posedge clk);
        #1;
        reset_outputs_zero("rst");
        seed_valid = 1'b0;
        out_ready  = 1'b0;
        rst_n      = 1'b1;

        // idle prefetch: four requests, then full with the default first word
        pulses = 0;
        tick();
        chk("first_next_after_reset", 32'(samp_gen_next), 32'd1);
        pulses += int'(samp_gen_next);
        for (int i = 0; i < 11; i++) begin
            tick();
            pulses += int'(samp_gen_next);
        end
        chk("idle_pulses", 32'(pulses), 32'd4);
        chk("idle_level", 32'(level), 32'd4);
        chk("idle_head", out_data, 32'hFEF3_16C3);
        chk("idle_next_off", 32'(gen_next), 32'd0);

        // continuous consumption for 100 cycles
        out_ready = 1'b1;
        pop_cnt   = 0;
        for (int i = 0; i < 100; i++) tick();
        chk("stream_pops", 32'(pop_cnt), 32'd100);
        vectors++;
        assert (max_level <= 4) else begin
            miscompares++;
            $error("FAIL level_max observed=%0d expected<=4", max_level);
        end
        out_ready = 1'b0;
        repeat (6) tick();
        chk("refill_level", 32'(level), 32'd4);

        // back-to-back seed 1,0,0,0 while full; pop in the flush cycle is dropped
        out_ready = 1'b1;
        seed_word(32'h1, 0);
        out_ready = 1'b0;
        chk("flush_level", 32'(level), 32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        seed_word(32'h0, 1);
        seed_word(32'h0, 2);
        seed_word(32'h0, 3);
        tick();
        chk("resume_next", 32'(samp_gen_next), 32'd1);
        tick();
        chk("post_seed_head", out_data, 32'h0000_0081);
        chk("post_seed_level", 32'(level), 32'd1);

        // push and pop together at level 1
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("pushpop_l1_level", 32'(level), 32'd1);
        chk("pushpop_l1_head", out_data, sb[0]);

        // push and pop together at the highest reachable level
        repeat (6) tick();
        chk("full_again", 32'(level), 32'd4);
        out_ready = 1'b1;
        tick();
        tick();
        chk("pushpop_hi_sample", 32'(samp_level), 32'd3);
        out_ready = 1'b0;
        chk("pushpop_hi_level", 32'(level), 32'd3);

        // seed with a ten-cycle gap before word 2
        repeat (6) tick();
        seed_word(32'h2, 0);
        seed_word(32'h0, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("gap_no_next", 32'(samp_gen_next), 32'd0);
            chk("gap_out_valid", 32'(samp_out_valid), 32'd0);
        end
        seed_word(32'h0, 2);
        seed_word(32'h3, 3);
        for (int i = 0; i < 10; i++) begin
            if (out_valid) break;
            tick();
        end
        chk("gap_wait_valid", 32'(out_valid), 32'd1);
        chk("gap_first_word", out_data, 32'h0000_0282);

        // reset in the middle of a seed load
        repeat (6) tick();
        seed_word(32'h1111_1111, 0);
        seed_word(32'h2222_2222, 1);
        seed_valid = 1'b1;
        out_ready  = 1'b1;
        rst_n      = 1'b0;
        #1;
        reset_outputs_zero("midseed_rst");
        seed_valid = 1'b0;
        out_ready  = 1'b0;
        sb.delete();
        bidx = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk("midseed_next_after_release", 32'(samp_gen_next), 32'd1);
        repeat (6) tick();
        chk("midseed_refill", 32'(level), 32'd4);
        out_ready = 1'b1;
        repeat (6) tick();
        out_ready = 1'b0;
        chk("no_next_with_write", 32'(both_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
